decoder_pipe: RTL and testbench

//  Registered successor of the ID-stage control decoder: decodes a 32-bit instruction into

---
 rtl/decoder_pipe_if.sv | 46 ++++
 rtl/decoder_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_decoder_pipe.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_pipe_if.sv
// decoder_pipe_if: instruction-in / decoded-control-out bundle for decoder_pipe.
// Latency: none, wiring only.
// Backpressure: instr_ready is driven by the decoder, ctrl_ready by the downstream ID/EX register.
interface decoder_pipe_if #(
    parameter int XLEN          = 32,
    parameter int NUM_DMA_CH    = 2,
    parameter int PIM_BEATS_MAX = 4
);
    localparam int MASK_W = XLEN / 8;
    localparam int CH_W   = (NUM_DMA_CH > 1) ? $clog2(NUM_DMA_CH) : 1;
    localparam int BEAT_W = (PIM_BEATS_MAX > 1) ? $clog2(PIM_BEATS_MAX) : 1;

    // instruction side
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;

    // control side
    logic              ctrl_valid;
    logic              ctrl_ready;
    logic              reg_write;
    logic [MASK_W-1:0] d_size;
    logic              d_unsigned;
    logic [2:0]        mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              dma_en;
    logic [CH_W-1:0]   dma_ch;
    logic [BEAT_W-1:0] dma_beat;
    logic              dma_last;
    logic              illegal;

    // decoder's view
    modport slave (
        input  instr_valid, instr, ctrl_ready,
        output instr_ready, ctrl_valid, reg_write, d_size, d_unsigned, mem_to_reg,
               mem_read, mem_write, dma_en, dma_ch, dma_beat, dma_last, illegal
    );

    // producer/consumer view
    modport master (
        output instr_valid, instr, ctrl_ready,
        input  instr_ready, ctrl_valid, reg_write, d_size, d_unsigned, mem_to_reg,
               mem_read, mem_write, dma_en, dma_ch, dma_beat, dma_last, illegal
    );
endinterface

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered ID-stage control decoder; PIM instructions expand into 1..PIM_BEATS_MAX DMA beats.
// Latency: 1 cycle from instruction accept to valid controls; a multi-beat PIM holds the pipe for N beats.
// Backpressure: single entry; instr_ready drops while a result is stalled or a PIM sequence is running.
// Optional feature: define DECODER_ILLEGAL_TRAP_EN to flag illegal encodings on illegal (else tied 0).
module decoder_pipe #(
    parameter int XLEN          = 32,
    parameter int NUM_DMA_CH    = 2,
    parameter int PIM_BEATS_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_pipe_if.slave bus
);
    localparam int MASK_W = XLEN / 8;
    localparam int CH_W   = (NUM_DMA_CH > 1) ? $clog2(NUM_DMA_CH) : 1;
    localparam int BEAT_W = (PIM_BEATS_MAX > 1) ? $clog2(PIM_BEATS_MAX) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MASK = BEAT_W'(PIM_BEATS_MAX - 1);

    // opcode map
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_PIM    = 7'b0001011;  // custom-0
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_D  = 3'b011;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;
    localparam logic [2:0] FUNCT3_WU = 3'b110;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // writeback source select
    localparam logic [2:0] WB_ALU = 3'b000;
    localparam logic [2:0] WB_MEM = 3'b001;
    localparam logic [2:0] WB_PC4 = 3'b010;
    localparam logic [2:0] WB_IMM = 3'b011;
    localparam logic [2:0] WB_MUL = 3'b101;

    localparam logic [MASK_W-1:0] MASK_B = MASK_W'(4'h1);
    localparam logic [MASK_W-1:0] MASK_H = MASK_W'(4'h3);
    localparam logic [MASK_W-1:0] MASK_W4 = MASK_W'(4'hF);
    localparam logic [MASK_W-1:0] MASK_D = '1;

    typedef struct packed {
        logic              reg_write;
        logic [MASK_W-1:0] d_size;
        logic              d_unsigned;
        logic [2:0]        mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              dma_en;
        logic [CH_W-1:0]   dma_ch;
        logic [BEAT_W-1:0] dma_beat;
        logic              dma_last;
        logic              illegal;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, OUT, PIM_SEQ} state_t;

    state_t            state;
    logic              ctrl_vld;
    ctrl_t             ctrl_q;
    logic [BEAT_W-1:0] last_beat;

    ctrl_t             dec;
    logic              dec_bad;
    logic              dec_pim;
    logic [BEAT_W-1:0] dec_beats_m1;
    logic [BEAT_W-1:0] beat_next;
    logic              instr_rdy;
    logic              accept;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];
    assign f7     = bus.instr[31:25];

    // rd/rs1/rs2 fields carry no control information here
    logic unused_fields;
    assign unused_fields = ^bus.instr[24:7] ^ ^bus.instr[11:7];

    // the pipe register is the only storage: accept when it is empty or draining, never mid-PIM
    assign instr_rdy = (state != PIM_SEQ) && (!ctrl_vld || bus.ctrl_ready);
    assign accept    = bus.instr_valid && instr_rdy;
    assign beat_next = ctrl_q.dma_beat + BEAT_W'(1);

    // upper f7 bits beyond the beat field are ignored
    assign dec_beats_m1 = bus.instr[25 +: BEAT_W] & BEAT_MASK;

    // combinational decode of the presented instruction; illegal encodings collapse to all-zero controls
    always_comb begin
        dec     = '0;
        dec_bad = 1'b0;
        dec_pim = 1'b0;
        case (opcode)
            OPCODE_OP: begin
                if (f7 == FUNCT7_MULDIV) begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = WB_MUL;
                end else if (f7 == FUNCT7_BASE || f7 == FUNCT7_ALT) begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = WB_ALU;
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OPCODE_OP_IMM, OPCODE_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_ALU;
            end
            OPCODE_JAL, OPCODE_JALR: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_PC4;
            end
            OPCODE_LUI: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_IMM;
            end
            OPCODE_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = WB_MEM;
                case (f3)
                    FUNCT3_B:  dec.d_size = MASK_B;
                    FUNCT3_H:  dec.d_size = MASK_H;
                    FUNCT3_W:  dec.d_size = MASK_W4;
                    FUNCT3_BU: begin dec.d_size = MASK_B; dec.d_unsigned = 1'b1; end
                    FUNCT3_HU: begin dec.d_size = MASK_H; dec.d_unsigned = 1'b1; end
                    FUNCT3_D:  if (XLEN == 64) dec.d_size = MASK_D; else dec_bad = 1'b1;
                    FUNCT3_WU: begin
                        if (XLEN == 64) begin
                            dec.d_size     = MASK_W4;
                            dec.d_unsigned = 1'b1;
                        end else begin
                            dec_bad = 1'b1;
                        end
                    end
                    default:   dec_bad = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                dec.mem_write = 1'b1;
                case (f3)
                    FUNCT3_B: dec.d_size = MASK_B;
                    FUNCT3_H: dec.d_size = MASK_H;
                    FUNCT3_W: dec.d_size = MASK_W4;
                    FUNCT3_D: if (XLEN == 64) dec.d_size = MASK_D; else dec_bad = 1'b1;
                    default:  dec_bad = 1'b1;
                endcase
            end
            OPCODE_PIM: begin
                if (32'(f3) < NUM_DMA_CH) begin
                    dec_pim       = 1'b1;
                    dec.mem_write = 1'b1;
                    dec.dma_en    = 1'b1;
                    dec.dma_ch    = CH_W'(f3);
                    dec.dma_last  = (dec_beats_m1 == '0);
                end else begin
                    dec_bad = 1'b1;
                end
            end
            default: dec_bad = 1'b1;
        endcase
        if (dec_bad) begin
            dec = '0;
`ifdef DECODER_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
`else
            dec.illegal = 1'b0;
`endif
        end
    end

    // pipe register + PIM beat sequencer: load on accept, step beats on ready, drain to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ctrl_vld  <= 1'b0;
            ctrl_q    <= '0;
            last_beat <= '0;
        end else if (accept) begin
            ctrl_vld  <= 1'b1;
            ctrl_q    <= dec;
            last_beat <= dec_pim ? dec_beats_m1 : '0;
            state     <= (dec_pim && dec_beats_m1 != '0) ? PIM_SEQ : OUT;
        end else if (ctrl_vld && bus.ctrl_ready) begin
            if (state == PIM_SEQ && ctrl_q.dma_beat != last_beat) begin
                ctrl_q.dma_beat <= beat_next;
                ctrl_q.dma_last <= (beat_next == last_beat);
            end else begin
                state    <= IDLE;
                ctrl_vld <= 1'b0;
                ctrl_q   <= '0;
            end
        end
    end

    assign bus.instr_ready = instr_rdy;
    assign bus.ctrl_valid  = ctrl_vld;
    assign bus.reg_write   = ctrl_q.reg_write;
    assign bus.d_size      = ctrl_q.d_size;
    assign bus.d_unsigned  = ctrl_q.d_unsigned;
    assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
    assign bus.mem_read    = ctrl_q.mem_read;
    assign bus.mem_write   = ctrl_q.mem_write;
    assign bus.dma_en      = ctrl_q.dma_en;
    assign bus.dma_ch      = ctrl_q.dma_ch;
    assign bus.dma_beat    = ctrl_q.dma_beat;
    assign bus.dma_last    = ctrl_q.dma_last;
    assign bus.illegal     = ctrl_q.illegal;
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed vectors for decoder_pipe, RV32 and RV64 instances side by side.
// Latency: checks sampled 1 time unit after the accepting clock edge.
// Backpressure: stall, PIM beat stepping and mid-sequence reset sequences written out by hand.
module tb_decoder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_pipe_if #(.XLEN(32), .NUM_DMA_CH(2), .PIM_BEATS_MAX(4)) bus32 ();
    decoder_pipe_if #(.XLEN(64), .NUM_DMA_CH(2), .PIM_BEATS_MAX(4)) bus64 ();

    decoder_pipe #(.XLEN(32), .NUM_DMA_CH(2), .PIM_BEATS_MAX(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32)
    );
    decoder_pipe #(.XLEN(64), .NUM_DMA_CH(2), .PIM_BEATS_MAX(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .bus(bus64)
    );

`ifdef DECODER_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        rw;
        logic [3:0]  size;
        logic        uns;
        logic [2:0]  src;
        logic        rd;
        logic        wr;
        logic        dma;
        logic        ch;
        logic        last;
        logic        bad;
    } vec_t;

    vec_t vecs[20];

    task automatic send32(input logic [31:0] ins);
        @(negedge clk);
        bus32.instr_valid = 1'b1;
        bus32.instr       = ins;
        @(posedge clk);
        #1;
        bus32.instr_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] ins);
        @(negedge clk);
        bus64.instr_valid = 1'b1;
        bus64.instr       = ins;
        @(posedge clk);
        #1;
        bus64.instr_valid = 1'b0;
    endtask

    // hold the first result for 3 cycles while the second instruction waits at the input
    task automatic stall_pair(input string nm, input logic [31:0] i0, input logic [2:0] s0,
                              input logic [31:0] i1, input logic [2:0] s1);
        @(negedge clk);
        bus32.ctrl_ready  = 1'b0;
        bus32.instr_valid = 1'b1;
        bus32.instr       = i0;
        @(posedge clk);
        #1;
        chk({nm, " first valid"}, 64'(bus32.ctrl_valid), 64'(1));
        chk({nm, " first src"}, 64'(bus32.mem_to_reg), 64'(s0));
        @(negedge clk);
        bus32.instr = i1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s hold valid c%0d", nm, c), 64'(bus32.ctrl_valid), 64'(1));
            chk($sformatf("%s hold src c%0d", nm, c), 64'(bus32.mem_to_reg), 64'(s0));
            chk($sformatf("%s instr_ready c%0d", nm, c), 64'(bus32.instr_ready), 64'(0));
        end
        @(negedge clk);
        bus32.ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        bus32.instr_valid = 1'b0;
        chk({nm, " second valid"}, 64'(bus32.ctrl_valid), 64'(1));
        chk({nm, " second src"}, 64'(bus32.mem_to_reg), 64'(s1));
        @(posedge clk);
        #1;
        chk({nm, " drained"}, 64'(bus32.ctrl_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic pat[4];
        logic [1:0] exp_beat[3];
        logic exp_last[3];

        //                 instr          rw size uns src    rd wr dma ch last bad
        vecs[0]  = '{32'h0002A303, 1, 4'hF, 0, 3'b001, 1, 0, 0, 0, 0, 0}; // lw
        vecs[1]  = '{32'h003100B3, 1, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 0}; // add
        vecs[2]  = '{32'h403100B3, 1, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 0}; // sub
        vecs[3]  = '{32'h023100B3, 1, 4'h0, 0, 3'b101, 0, 0, 0, 0, 0, 0}; // mul
        vecs[4]  = '{32'h00510093, 1, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 0}; // addi
        vecs[5]  = '{32'h123450B7, 1, 4'h0, 0, 3'b011, 0, 0, 0, 0, 0, 0}; // lui
        vecs[6]  = '{32'h008000EF, 1, 4'h0, 0, 3'b010, 0, 0, 0, 0, 0, 0}; // jal
        vecs[7]  = '{32'h000080E7, 1, 4'h0, 0, 3'b010, 0, 0, 0, 0, 0, 0}; // jalr
        vecs[8]  = '{32'h00001097, 1, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 0}; // auipc
        vecs[9]  = '{32'h00014083, 1, 4'h1, 1, 3'b001, 1, 0, 0, 0, 0, 0}; // lbu
        vecs[10] = '{32'h00015083, 1, 4'h3, 1, 3'b001, 1, 0, 0, 0, 0, 0}; // lhu
        vecs[11] = '{32'h00011083, 1, 4'h3, 0, 3'b001, 1, 0, 0, 0, 0, 0}; // lh
        vecs[12] = '{32'h00312023, 0, 4'hF, 0, 3'b000, 0, 1, 0, 0, 0, 0}; // sw
        vecs[13] = '{32'h00310023, 0, 4'h1, 0, 3'b000, 0, 1, 0, 0, 0, 0}; // sb
        vecs[14] = '{32'h00311023, 0, 4'h3, 0, 3'b000, 0, 1, 0, 0, 0, 0}; // sh
        vecs[15] = '{32'h00013083, 0, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 1}; // ld on RV32
        vecs[16] = '{32'h0000007F, 0, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 1}; // unknown opcode
        vecs[17] = '{32'h203100B3, 0, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 1}; // R-type f7=0x10
        vecs[18] = '{32'h0000300B, 0, 4'h0, 0, 3'b000, 0, 0, 0, 0, 0, 1}; // PIM ch 3 of 2
        vecs[19] = '{32'h0000100B, 0, 4'h0, 0, 3'b000, 0, 1, 1, 1, 1, 0}; // PIM 1 beat ch 1

        bus32.instr_valid = 1'b0;
        bus32.instr       = '0;
        bus32.ctrl_ready  = 1'b1;
        bus64.instr_valid = 1'b0;
        bus64.instr       = '0;
        bus64.ctrl_ready  = 1'b1;

        // reset state
        @(posedge clk);
        #1;
        chk("reset ctrl_valid", 64'(bus32.ctrl_valid), 64'(0));
        chk("reset reg_write", 64'(bus32.reg_write), 64'(0));
        chk("reset d_size", 64'(bus32.d_size), 64'(0));
        chk("reset dma_en", 64'(bus32.dma_en), 64'(0));
        chk("reset illegal", 64'(bus32.illegal), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset instr_ready", 64'(bus32.instr_ready), 64'(1));
        chk("post-reset ctrl_valid", 64'(bus32.ctrl_valid), 64'(0));

        // decode table, back-to-back at full throughput
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("v%0d instr_ready", i), 64'(bus32.instr_ready), 64'(1));
            send32(vecs[i].instr);
            chk($sformatf("v%0d ctrl_valid", i), 64'(bus32.ctrl_valid), 64'(1));
            chk($sformatf("v%0d reg_write", i), 64'(bus32.reg_write), 64'(vecs[i].rw));
            chk($sformatf("v%0d d_size", i), 64'(bus32.d_size), 64'(vecs[i].size));
            chk($sformatf("v%0d d_unsigned", i), 64'(bus32.d_unsigned), 64'(vecs[i].uns));
            chk($sformatf("v%0d mem_to_reg", i), 64'(bus32.mem_to_reg), 64'(vecs[i].src));
            chk($sformatf("v%0d mem_read", i), 64'(bus32.mem_read), 64'(vecs[i].rd));
            chk($sformatf("v%0d mem_write", i), 64'(bus32.mem_write), 64'(vecs[i].wr));
            chk($sformatf("v%0d dma_en", i), 64'(bus32.dma_en), 64'(vecs[i].dma));
            chk($sformatf("v%0d dma_ch", i), 64'(bus32.dma_ch), 64'(vecs[i].ch));
            chk($sformatf("v%0d dma_beat", i), 64'(bus32.dma_beat), 64'(0));
            chk($sformatf("v%0d dma_last", i), 64'(bus32.dma_last), 64'(vecs[i].last));
            chk($sformatf("v%0d illegal", i), 64'(bus32.illegal), 64'(vecs[i].bad & TRAP));
        end
        @(posedge clk);
        #1;
        chk("table drained", 64'(bus32.ctrl_valid), 64'(0));

        // backpressure: nothing lost or duplicated
        stall_pair("add/sub", 32'h003100B3, 3'b000, 32'h403100B3, 3'b000);
        stall_pair("lui/mul", 32'h123450B7, 3'b011, 32'h023100B3, 3'b101);

        // 3-beat PIM on channel 1, ready pattern 1,0,1,1, a LUI waiting at the input throughout
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        exp_beat[0] = 2'd1; exp_beat[1] = 2'd1; exp_beat[2] = 2'd2;
        exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b1;
        @(negedge clk);
        bus32.ctrl_ready  = 1'b1;
        bus32.instr_valid = 1'b1;
        bus32.instr       = 32'h0400100B;
        @(posedge clk);
        #1;
        bus32.instr = 32'h123450B7;
        chk("pim beat0 valid", 64'(bus32.ctrl_valid), 64'(1));
        chk("pim beat0 dma_en", 64'(bus32.dma_en), 64'(1));
        chk("pim beat0 mem_write", 64'(bus32.mem_write), 64'(1));
        chk("pim beat0 ch", 64'(bus32.dma_ch), 64'(1));
        chk("pim beat0 beat", 64'(bus32.dma_beat), 64'(0));
        chk("pim beat0 last", 64'(bus32.dma_last), 64'(0));
        chk("pim beat0 instr_ready", 64'(bus32.instr_ready), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus32.ctrl_ready = pat[k];
            if (k == 3) bus32.instr_valid = 1'b0;
            @(posedge clk);
            #1;
            if (k < 3) begin
                chk($sformatf("pim step%0d valid", k), 64'(bus32.ctrl_valid), 64'(1));
                chk($sformatf("pim step%0d dma_en", k), 64'(bus32.dma_en), 64'(1));
                chk($sformatf("pim step%0d beat", k), 64'(bus32.dma_beat), 64'(exp_beat[k]));
                chk($sformatf("pim step%0d last", k), 64'(bus32.dma_last), 64'(exp_last[k]));
                chk($sformatf("pim step%0d ch", k), 64'(bus32.dma_ch), 64'(1));
                chk($sformatf("pim step%0d instr_ready", k), 64'(bus32.instr_ready), 64'(0));
            end else begin
                chk("pim done valid", 64'(bus32.ctrl_valid), 64'(0));
                chk("pim done dma_en", 64'(bus32.dma_en), 64'(0));
                chk("pim done reg_write", 64'(bus32.reg_write), 64'(0));
                chk("pim done instr_ready", 64'(bus32.instr_ready), 64'(1));
            end
        end

        // reset on beat 1 of a 4-beat PIM
        @(negedge clk);
        bus32.ctrl_ready  = 1'b1;
        bus32.instr_valid = 1'b1;
        bus32.instr       = 32'h0600000B;
        @(posedge clk);
        #1;
        bus32.instr_valid = 1'b0;
        chk("rst-pim beat0", 64'(bus32.dma_beat), 64'(0));
        @(posedge clk);
        #1;
        chk("rst-pim beat1", 64'(bus32.dma_beat), 64'(1));
        chk("rst-pim beat1 dma_en", 64'(bus32.dma_en), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst-pim async valid", 64'(bus32.ctrl_valid), 64'(0));
        chk("rst-pim async dma_en", 64'(bus32.dma_en), 64'(0));
        chk("rst-pim async mem_write", 64'(bus32.mem_write), 64'(0));
        chk("rst-pim async beat", 64'(bus32.dma_beat), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst-pim idle valid", 64'(bus32.ctrl_valid), 64'(0));
        chk("rst-pim idle dma_en", 64'(bus32.dma_en), 64'(0));
        chk("rst-pim instr_ready", 64'(bus32.instr_ready), 64'(1));

        // RV64 widths
        send64(32'h00013083);
        chk("rv64 ld valid", 64'(bus64.ctrl_valid), 64'(1));
        chk("rv64 ld mask", 64'(bus64.d_size), 64'(8'hFF));
        chk("rv64 ld unsigned", 64'(bus64.d_unsigned), 64'(0));
        chk("rv64 ld mem_read", 64'(bus64.mem_read), 64'(1));
        chk("rv64 ld illegal", 64'(bus64.illegal), 64'(0));
        send64(32'h00016083);
        chk("rv64 lwu mask", 64'(bus64.d_size), 64'(8'h0F));
        chk("rv64 lwu unsigned", 64'(bus64.d_unsigned), 64'(1));
        chk("rv64 lwu src", 64'(bus64.mem_to_reg), 64'(3'b001));
        send64(32'h00313023);
        chk("rv64 sd mask", 64'(bus64.d_size), 64'(8'hFF));
        chk("rv64 sd mem_write", 64'(bus64.mem_write), 64'(1));
        chk("rv64 sd reg_write", 64'(bus64.reg_write), 64'(0));
        @(posedge clk);
        #1;
        chk("rv64 drained", 64'(bus64.ctrl_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
